rd_mux_sdram: RTL and testbench

//  Read-path counterpart of the write-side SDRAM/GPIO mux. Accepts one CPU read, routes it by rd_address MSB
//  (1=GPIO, 0=SDRAM), waits for the target, returns data with a 1-cycle rd_valid pulse; stalls CPU meanwhile.

---
 rtl/rd_mux_sdram_pkg.sv | 18 +
 rtl/rd_mux_sdram_timeout_cnt.sv | 31 +++
 rtl/rd_mux_sdram.sv | 138 +++++++++++++
 tb/tb_rd_mux_sdram.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_mux_sdram_pkg.sv
// Shared types for the SDRAM/GPIO read-side mux.
// FSM encoding and counter sizing helper.
package rd_mux_sdram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GPIO_REQ,
        GPIO_CAP,
        SDRAM_WAIT,
        RESP
    } state_t;

    // Counter never needs to reach TIMEOUT_CYCLES itself, only TIMEOUT_CYCLES-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/rd_mux_sdram_timeout_cnt.sv
// SDRAM wait-cycle counter for the read-side mux.
// Flags expiry on the last allowed wait cycle.
module rd_timeout_cnt
    import rd_mux_sdram_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at LAST; the FSM always leaves the wait state there anyway.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/rd_mux_sdram.sv
// Read-side mux: routes one CPU read to GPIO (address MSB=1) or SDRAM,
// returns data with a one-cycle rd_valid pulse and stalls the CPU meanwhile.
module rd_mux_sdram
    import rd_mux_sdram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  stall,
    output logic                  rd_en_sdram,
    output logic [ADDR_WIDTH-1:0] rd_address_sdram,
    input  logic                  rd_valid_sdram,
    input  logic [DATA_WIDTH-1:0] rd_data_sdram,
    output logic                  rd_en_gpio,
    output logic [ADDR_WIDTH-1:0] rd_address_gpio,
    input  logic [DATA_WIDTH-1:0] rd_data_gpio
);

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  valid_nxt;
    logic                  err_nxt;
    logic                  en_sdram_nxt;
    logic [ADDR_WIDTH-1:0] addr_sdram_nxt;
    logic                  en_gpio_nxt;
    logic [ADDR_WIDTH-1:0] addr_gpio_nxt;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  expired;

    rd_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    always_comb begin
        state_nxt      = state;
        data_nxt       = rd_data;
        valid_nxt      = 1'b0;
        err_nxt        = rd_err;
        en_sdram_nxt   = rd_en_sdram;
        addr_sdram_nxt = rd_address_sdram;
        en_gpio_nxt    = 1'b0;
        addr_gpio_nxt  = rd_address_gpio;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;

        unique case (state)
            IDLE: begin
                if (rd_en) begin
                    if (rd_address[ADDR_WIDTH-1]) begin
                        addr_gpio_nxt = rd_address;
                        en_gpio_nxt   = 1'b1;
                        state_nxt     = GPIO_REQ;
                    end else begin
                        addr_sdram_nxt = rd_address;
                        en_sdram_nxt   = 1'b1;
                        state_nxt      = SDRAM_WAIT;
                    end
                end
            end
            GPIO_REQ: begin
                state_nxt = GPIO_CAP;
            end
            GPIO_CAP: begin
                data_nxt  = rd_data_gpio;
                err_nxt   = 1'b0;
                valid_nxt = 1'b1;
                state_nxt = RESP;
            end
            SDRAM_WAIT: begin
                cnt_en = 1'b1;
                // Data arriving on the last allowed cycle still beats the timeout.
                if (rd_valid_sdram) begin
                    data_nxt     = rd_data_sdram;
                    err_nxt      = 1'b0;
                    en_sdram_nxt = 1'b0;
                    valid_nxt    = 1'b1;
                    state_nxt    = RESP;
                end else if (expired) begin
                    data_nxt     = '0;
                    err_nxt      = 1'b1;
                    en_sdram_nxt = 1'b0;
                    valid_nxt    = 1'b1;
                    state_nxt    = RESP;
                end
            end
            RESP: begin
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rd_data          <= '0;
            rd_valid         <= 1'b0;
            rd_err           <= 1'b0;
            rd_en_sdram      <= 1'b0;
            rd_address_sdram <= '0;
            rd_en_gpio       <= 1'b0;
            rd_address_gpio  <= '0;
        end else begin
            state            <= state_nxt;
            rd_data          <= data_nxt;
            rd_valid         <= valid_nxt;
            rd_err           <= err_nxt;
            rd_en_sdram      <= en_sdram_nxt;
            rd_address_sdram <= addr_sdram_nxt;
            rd_en_gpio       <= en_gpio_nxt;
            rd_address_gpio  <= addr_gpio_nxt;
        end
    end

    assign stall = ((state != IDLE) && (state != RESP))
                 || ((state == IDLE) && rd_en);

endmodule

// File: tb/tb_rd_mux_sdram.sv
// Directed self-checking bench for rd_mux_sdram (TIMEOUT_CYCLES=8).
// Cycle 0 is the cycle rd_en is first presented; cycle n follows n edges later.
module tb_rd_mux_sdram;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [31:0] rd_address;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic        stall;
    logic        rd_en_sdram;
    logic [31:0] rd_address_sdram;
    logic        rd_valid_sdram;
    logic [31:0] rd_data_sdram;
    logic        rd_en_gpio;
    logic [31:0] rd_address_gpio;
    logic [31:0] rd_data_gpio;

    int errors = 0;
    int checks = 0;

    rd_mux_sdram #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .rd_address      (rd_address),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_err          (rd_err),
        .stall           (stall),
        .rd_en_sdram     (rd_en_sdram),
        .rd_address_sdram(rd_address_sdram),
        .rd_valid_sdram  (rd_valid_sdram),
        .rd_data_sdram   (rd_data_sdram),
        .rd_en_gpio      (rd_en_gpio),
        .rd_address_gpio (rd_address_gpio),
        .rd_data_gpio    (rd_data_gpio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        rd_en          = 1'b0;
        rd_address     = $urandom;
        rd_valid_sdram = 1'($urandom_range(0, 1));
        rd_data_sdram  = $urandom;
        rd_data_gpio   = $urandom;
        tick();
        tick();
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_err: got %b%b want 00", rd_valid, rd_err);
        end
        checks++;
        if (rd_en_sdram !== 1'b0 || rd_address_sdram !== 32'h0) begin
            errors++;
            $display("FAIL reset_sdram: got en=%b addr=%h want 0/0",
                     rd_en_sdram, rd_address_sdram);
        end
        checks++;
        if (rd_en_gpio !== 1'b0 || rd_address_gpio !== 32'h0) begin
            errors++;
            $display("FAIL reset_gpio: got en=%b addr=%h want 0/0",
                     rd_en_gpio, rd_address_gpio);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
        rst            = 1'b0;
        rd_valid_sdram = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_en_sdram !== 1'b0 || rd_en_gpio !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got v=%b s=%b g=%b want 000",
                     rd_valid, rd_en_sdram, rd_en_gpio);
        end
    endtask

    task automatic test_gpio();
        rd_en        = 1'b1;
        rd_address   = 32'h8000_0010;
        rd_data_gpio = 32'hDEAD_0000;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL gpio_stall_c0: got %b want 1", stall);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            rd_data_gpio = (c == 2) ? 32'hCAFE_0001 : 32'hDEAD_0000 + c;
            checks++;
            if (rd_en_gpio !== (c == 1) || rd_en_sdram !== 1'b0) begin
                errors++;
                $display("FAIL gpio_strobe c%0d: got g=%b s=%b want g=%b s=0",
                         c, rd_en_gpio, rd_en_sdram, c == 1);
            end
            checks++;
            if (rd_valid !== (c == 3) || stall !== (c < 3)) begin
                errors++;
                $display("FAIL gpio_valid_stall c%0d: got v=%b st=%b want v=%b st=%b",
                         c, rd_valid, stall, c == 3, c < 3);
            end
            if (c == 1) begin
                checks++;
                if (rd_address_gpio !== 32'h8000_0010) begin
                    errors++;
                    $display("FAIL gpio_addr: got %h want 80000010", rd_address_gpio);
                end
            end
            if (c == 3) begin
                checks++;
                if (rd_data !== 32'hCAFE_0001 || rd_err !== 1'b0) begin
                    errors++;
                    $display("FAIL gpio_data: got %h err=%b want cafe0001 err=0",
                             rd_data, rd_err);
                end
                rd_en = 1'b0;
            end
        end
    endtask

    // Drives one SDRAM read; k = cycle carrying rd_valid_sdram (0 = never).
    task automatic sdram_txn(input logic [31:0] addr, input int k,
                             input logic [31:0] data, input logic exp_err);
        int end_c;
        int hi;
        end_c          = (k == 0) ? TO : k;
        hi             = 0;
        rd_en          = 1'b1;
        rd_address     = addr;
        rd_valid_sdram = 1'b0;
        rd_data_sdram  = 32'h0BAD_0BAD;
        for (int c = 1; c <= end_c + 1; c++) begin
            tick();
            rd_valid_sdram = (c == k);
            rd_data_sdram  = (c == k) ? data : 32'h0BAD_0BAD;
            if (c >= 2) rd_address = 32'h0000_0F00;
            if (rd_en_sdram === 1'b1) hi++;
            checks++;
            if (rd_en_sdram !== (c <= end_c) || rd_en_gpio !== 1'b0) begin
                errors++;
                $display("FAIL sdram_en %h c%0d: got s=%b g=%b want s=%b g=0",
                         addr, c, rd_en_sdram, rd_en_gpio, c <= end_c);
            end
            if (c <= end_c) begin
                checks++;
                if (rd_address_sdram !== addr) begin
                    errors++;
                    $display("FAIL sdram_addr c%0d: got %h want %h",
                             c, rd_address_sdram, addr);
                end
            end
            checks++;
            if (rd_valid !== (c == end_c + 1) || stall !== (c <= end_c)) begin
                errors++;
                $display("FAIL sdram_valid_stall %h c%0d: got v=%b st=%b want v=%b st=%b",
                         addr, c, rd_valid, stall, c == end_c + 1, c <= end_c);
            end
        end
        checks++;
        if (rd_data !== (exp_err ? 32'h0 : data) || rd_err !== exp_err) begin
            errors++;
            $display("FAIL sdram_result %h: got %h err=%b want %h err=%b",
                     addr, rd_data, rd_err, exp_err ? 32'h0 : data, exp_err);
        end
        checks++;
        if (hi != end_c) begin
            errors++;
            $display("FAIL sdram_en_len %h: got %0d want %0d", addr, hi, end_c);
        end
        rd_en          = 1'b0;
        rd_valid_sdram = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL sdram_after %h: got v=%b st=%b want 00", addr, rd_valid, stall);
        end
    endtask

    task automatic test_sdram();
        sdram_txn(32'h0000_0100, 5, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_timeout();
        sdram_txn(32'h0000_0104, 0, 32'h0, 1'b1);
        sdram_txn(32'h0000_0108, TO, 32'hA5A5_5A5A, 1'b0);
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses        = 0;
        rd_en         = 1'b1;
        rd_address    = 32'h8000_0020;
        rd_data_gpio  = 32'h0BAD_F00D;
        rd_data_sdram = 32'h5555_AAAA;
        for (int c = 1; c <= 7; c++) begin
            tick();
            rd_valid_sdram = (c == 2) || (c == 6);
            if (rd_valid === 1'b1) pulses++;
            checks++;
            if (rd_valid !== (c == 3 || c == 7) || stall !== !(c == 3 || c == 7)) begin
                errors++;
                $display("FAIL b2b_valid_stall c%0d: got v=%b st=%b want v=%b st=%b",
                         c, rd_valid, stall, c == 3 || c == 7, !(c == 3 || c == 7));
            end
            if (c == 3) begin
                checks++;
                if (rd_data !== 32'h0BAD_F00D || rd_err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_first: got %h err=%b want 0badf00d err=0",
                             rd_data, rd_err);
                end
                rd_address = 32'h0000_0200;
            end
            if (c == 4 || c == 5) begin
                checks++;
                if (rd_en_sdram !== (c == 5) || rd_en_gpio !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_sdram_start c%0d: got s=%b g=%b want s=%b g=0",
                             c, rd_en_sdram, rd_en_gpio, c == 5);
                end
            end
            if (c == 7) begin
                checks++;
                if (rd_data !== 32'h5555_AAAA || rd_address_sdram !== 32'h0000_0200) begin
                    errors++;
                    $display("FAIL b2b_second: got %h addr=%h want 5555aaaa addr=200",
                             rd_data, rd_address_sdram);
                end
                rd_en = 1'b0;
            end
        end
        rd_valid_sdram = 1'b0;
        tick();
        checks++;
        if (pulses != 2 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d v=%b want 2 v=0", pulses, rd_valid);
        end
    endtask

    task automatic test_mid_reset();
        rd_en      = 1'b1;
        rd_address = 32'h0000_0300;
        tick();
        tick();
        checks++;
        if (rd_en_sdram !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got %b want 1", rd_en_sdram);
        end
        rst   = 1'b1;
        rd_en = 1'b0;
        tick();
        checks++;
        if (rd_en_sdram !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: got s=%b v=%b want 00", rd_en_sdram, rd_valid);
        end
        rst            = 1'b0;
        rd_valid_sdram = 1'b1;
        tick();
        rd_valid_sdram = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: got v=%b st=%b want 00", rd_valid, stall);
        end
        sdram_txn(32'h0000_0400, 3, 32'h0F0F_0F0F, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_gpio();
        test_sdram();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
